// File: rtl/freq_step_counter.sv
// ---------------------------------------------------------------------------------------------
// freq_step_counter
//
// Saturating up/down frequency-count register driven by a signed motor speed. Every rising
// edge of the (possibly asynchronous, slow) tick input requests one update. The speed sign
// picks the direction, and its magnitude picks the step size. A synchronous load overrides any
// coincident update. The count always stays within [MIN_CNT, MAX_CNT].
//
// Ports
//   i_clk       in   1        system clock; all state changes on the rising edge
//   i_rst_n     in   1        asynchronous active-low reset
//   i_tick      in   1        update strobe; each rising edge is one update request
//   i_valid     in   1        speed is valid; update requests are dropped while low
//   i_speed     in   SPEED_W  signed motor speed (sign = direction, magnitude = step)
//   i_load      in   1        synchronous load request
//   i_load_val  in   WIDTH    value to load; clamped to [MIN_CNT, MAX_CNT]
//   o_count     out  WIDTH    current frequency count
//   o_at_min    out  1        count == MIN_CNT
//   o_at_max    out  1        count == MAX_CNT
//   o_changed   out  1        one-cycle pulse: count changed on the previous clock edge
//
// Assumes WIDTH > SPEED_W, MIN_CNT < MAX_CNT < 2**WIDTH and MIN_CNT <= INIT_CNT <= MAX_CNT.
// ---------------------------------------------------------------------------------------------
module freq_step_counter #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned SPEED_W    = 8,
  parameter int unsigned MIN_CNT    = 1,
  parameter int unsigned MAX_CNT    = 655,
  parameter int unsigned INIT_CNT   = 419,
  parameter int unsigned DEADBAND   = 0,
  parameter int unsigned STEP_SHIFT = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_tick,
  input  logic                      i_valid,
  input  logic signed [SPEED_W-1:0] i_speed,
  input  logic                      i_load,
  input  logic        [WIDTH-1:0]   i_load_val,
  output logic        [WIDTH-1:0]   o_count,
  output logic                      o_at_min,
  output logic                      o_at_max,
  output logic                      o_changed
);

  localparam logic [WIDTH-1:0]   MinCnt   = WIDTH'(MIN_CNT);
  localparam logic [WIDTH-1:0]   MaxCnt   = WIDTH'(MAX_CNT);
  localparam logic [WIDTH-1:0]   InitCnt  = WIDTH'(INIT_CNT);
  localparam logic [SPEED_W:0]   Deadband = (SPEED_W + 1)'(DEADBAND);
  localparam logic [SPEED_W:0]   OneMag   = (SPEED_W + 1)'(1);
  localparam logic [WIDTH:0]     OneWide  = (WIDTH + 1)'(1);

  // -------------------------------------------------------------------------------------------
  // Tick synchroniser and rising-edge detect
  // -------------------------------------------------------------------------------------------
  logic r_s1, r_s2, r_s3;
  logic w_upd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_tick;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Because r_s3 clears on reset, a tick held high across reset release is a fresh edge.
  assign w_upd = r_s2 & ~r_s3;

  // -------------------------------------------------------------------------------------------
  // Step computation
  // -------------------------------------------------------------------------------------------
  logic             w_neg;
  logic [SPEED_W:0] w_speed_ext;
  logic [SPEED_W:0] w_mag;
  logic [WIDTH:0]   w_mag_wide;
  logic [WIDTH:0]   w_step;

  assign w_neg       = i_speed[SPEED_W-1];
  assign w_speed_ext = {i_speed[SPEED_W-1], i_speed};
  // One extra bit so the most negative speed negates to its true magnitude.
  assign w_mag       = w_neg ? (~w_speed_ext + OneMag) : w_speed_ext;
  assign w_mag_wide  = {{(WIDTH - SPEED_W){1'b0}}, w_mag};
  assign w_step      = (w_mag_wide >> STEP_SHIFT) + OneWide;

  // -------------------------------------------------------------------------------------------
  // Saturating candidates
  // -------------------------------------------------------------------------------------------
  logic             [WIDTH-1:0] r_count;
  logic             [WIDTH:0]   w_cnt_wide;
  logic             [WIDTH:0]   w_sum;
  logic             [WIDTH:0]   w_diff;
  logic             [WIDTH-1:0] w_up_val;
  logic             [WIDTH-1:0] w_dn_val;
  logic             [WIDTH-1:0] w_load_clamped;

  assign w_cnt_wide = {1'b0, r_count};
  assign w_sum      = w_cnt_wide + w_step;
  assign w_diff     = w_cnt_wide - w_step;

  assign w_up_val = (w_sum > {1'b0, MaxCnt}) ? MaxCnt : w_sum[WIDTH-1:0];
  // w_diff[WIDTH] set means the step exceeded the count (borrow), so clamp rather than wrap.
  assign w_dn_val = (w_diff[WIDTH] || (w_diff < {1'b0, MinCnt})) ? MinCnt : w_diff[WIDTH-1:0];

  always_comb begin
    w_load_clamped = i_load_val;
    if (i_load_val < MinCnt) begin
      w_load_clamped = MinCnt;
    end else if (i_load_val > MaxCnt) begin
      w_load_clamped = MaxCnt;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Next-state selection
  // -------------------------------------------------------------------------------------------
  logic             w_step_en;
  logic [WIDTH-1:0] w_count_d;

  // Requests arriving while invalid, inside the deadband or at zero speed are dropped.
  assign w_step_en = w_upd & i_valid & (w_mag > Deadband) & (i_speed != '0);

  always_comb begin
    w_count_d = r_count;
    if (i_load) begin
      w_count_d = w_load_clamped;
    end else if (w_step_en) begin
      w_count_d = w_neg ? w_dn_val : w_up_val;
    end
  end

  logic r_changed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count   <= InitCnt;
      r_changed <= 1'b0;
    end else begin
      r_count   <= w_count_d;
      r_changed <= (w_count_d != r_count);
    end
  end

  // -------------------------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------------------------
  assign o_count   = r_count;
  assign o_at_min  = (r_count == MinCnt);
  assign o_at_max  = (r_count == MaxCnt);
  assign o_changed = r_changed;

endmodule

// File: tb/tb_freq_step_counter.sv
// ---------------------------------------------------------------------------------------------
// tb_freq_step_counter
//
// Directed stimulus for freq_step_counter. A behavioural model schedules each tick rising edge
// as an update two edges later. It applies load/valid/speed rules in plain integer arithmetic,
// and a compare process checks every DUT output against it on each falling edge. Literal
// expectations at key points pin both the DUT and the model.
// ---------------------------------------------------------------------------------------------
module tb_freq_step_counter;

  localparam int MinC  = 1;
  localparam int MaxC  = 655;
  localparam int InitC = 419;

  logic              clk;
  logic              rst_n;
  logic              tick;
  logic              valid;
  logic signed [7:0] speed;
  logic              load;
  logic [15:0]       load_val;
  logic [15:0]       count;
  logic              at_min;
  logic              at_max;
  logic              changed;

  int n_checks = 0;
  int n_errors = 0;

  freq_step_counter dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_tick     (tick),
    .i_valid    (valid),
    .i_speed    (speed),
    .i_load     (load),
    .i_load_val (load_val),
    .o_count    (count),
    .o_at_min   (at_min),
    .o_at_max   (at_max),
    .o_changed  (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------------------------
  // Behavioural model
  // ------------------------------------------------------------------------------------------
  int m_count;
  bit m_changed;
  int m_edge;
  bit m_last_tick;
  int m_due[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count     <= InitC;
      m_changed   <= 1'b0;
      m_edge      = 0;
      m_last_tick = 1'b0;
      m_due.delete();
    end else begin
      int  nc;
      int  sp;
      int  mag;
      int  step;
      bit  due;
      m_edge++;
      due = 1'b0;
      if (m_due.size() > 0 && m_due[0] == m_edge) begin
        due = 1'b1;
        void'(m_due.pop_front());
      end
      nc  = m_count;
      sp  = int'(speed);
      mag = (sp < 0) ? -sp : sp;
      if (load) begin
        nc = int'(load_val);
        if (nc < MinC) nc = MinC;
        if (nc > MaxC) nc = MaxC;
      end else if (due && valid && mag > 0) begin
        step = 1 + mag / 16;
        if (sp > 0) nc = (m_count + step > MaxC) ? MaxC : m_count + step;
        else        nc = (m_count - step < MinC) ? MinC : m_count - step;
      end
      // A rising tick seen at this edge takes effect two edges later.
      if (tick && !m_last_tick) m_due.push_back(m_edge + 2);
      m_last_tick = tick;
      m_changed <= (nc != m_count);
      m_count   <= nc;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("count", int'(count), m_count);
    check("at_min", int'(at_min), int'(m_count == MinC));
    check("at_max", int'(at_max), int'(m_count == MaxC));
    check("changed", int'(changed), int'(m_changed));
  end

  // ------------------------------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------------------------------
  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One-cycle tick pulse; returns at the falling edge after the update edge.
  task automatic pulse_and_settle();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    wait_neg(2);
  endtask

  task automatic do_load(input int v);
    @(negedge clk);
    load     = 1'b1;
    load_val = 16'(v);
    @(negedge clk);
    load     = 1'b0;
  endtask

  int speeds[6] = '{17, -33, 127, -1, 48, -128};

  initial begin
    tick     = 1'b0;
    valid    = 1'b1;
    speed    = 8'sd5;
    load     = 1'b1;
    load_val = 16'd77;
    rst_n    = 1'b1;

    // Asynchronous reset, before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_count", int'(count), InitC);
    check("rst_at_min", int'(at_min), 0);
    check("rst_at_max", int'(at_max), 0);
    check("rst_changed", int'(changed), 0);
    check("rst_model", m_count, InitC);
    load = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(2);

    // Unit step and latency.
    speed = 8'sd1;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk);
    check("lat_before", int'(count), 419);
    @(negedge clk);
    check("lat_count", int'(count), 420);
    check("lat_changed", int'(changed), 1);
    check("lat_model", m_count, 420);
    @(negedge clk);
    check("lat_changed_drop", int'(changed), 0);

    // Proportional step and upper saturation.
    do_load(650);
    check("load_650", int'(count), 650);
    speed = 8'sd100;
    pulse_and_settle();
    check("sat_hi", int'(count), 655);
    check("sat_hi_flag", int'(at_max), 1);
    check("sat_hi_model", m_count, 655);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sat_hi_hold", int'(count), 655);
    check("sat_hi_nochg", int'(changed), 0);

    // Most negative speed, lower saturation without wrap.
    do_load(5);
    speed = -8'sd128;
    pulse_and_settle();
    check("sat_lo", int'(count), 1);
    check("sat_lo_flag", int'(at_min), 1);
    check("sat_lo_model", m_count, 1);

    // Gating: invalid, zero speed, held tick.
    valid = 1'b0;
    speed = 8'sd1;
    pulse_and_settle();
    check("gate_valid", int'(count), 1);
    valid = 1'b1;
    speed = 8'sd0;
    pulse_and_settle();
    check("gate_zero", int'(count), 1);
    speed = 8'sd1;
    @(negedge clk) tick = 1'b1;
    wait_neg(50);
    tick = 1'b0;
    wait_neg(3);
    check("held_tick", int'(count), 2);

    // Loads with clamping.
    do_load(2000);
    check("load_clamp_hi", int'(count), 655);
    do_load(0);
    check("load_clamp_lo", int'(count), 1);

    // Load coincident with the update edge wins.
    speed = 8'sd5;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk);
    load     = 1'b1;
    load_val = 16'd300;
    @(negedge clk) load = 1'b0;
    wait_neg(3);
    check("load_beats_tick", int'(count), 300);

    // Reset mid-tick; tick held across release gives one update.
    @(negedge clk) tick = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset", int'(count), 419);
    @(negedge clk) rst_n = 1'b1;
    wait_neg(6);
    check("reset_held_tick", int'(count), 420);
    tick = 1'b0;
    wait_neg(2);

    // Assorted speeds, both directions.
    foreach (speeds[i]) begin
      speed = 8'(speeds[i]);
      pulse_and_settle();
    end
    wait_neg(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
